fdc_sif: RTL and testbench

FDC_SIF -- requirements
Module: fdc_sif

---
 rtl/fdc_pkg.sv | 55 +++++
 rtl/fdc_buf.sv | 30 +++
 rtl/fdc_sif.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_fdc_sif.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdc_pkg.sv
// Floppy controller serial interface: shared types and constants.
// Holds the controller state encoding, the command function codes, the
// status byte bit positions and the synchronizer lane layout.
package fdc_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DECODE,
    ST_RXDATA,
    ST_TXDATA,
    ST_STAT,
    ST_ABORT
  } fdc_state_e;

  // Transmit byte sub-phase: fetch from RAM, load shift register, shift out
  typedef enum logic [1:0] {
    TX_FETCH,
    TX_LOAD,
    TX_SHIFT
  } tx_phase_e;

  // Function field cmd[3:1]
  localparam logic [2:0] FN_FILL   = 3'b000;
  localparam logic [2:0] FN_EMPTY  = 3'b001;
  localparam logic [2:0] FN_STATUS = 3'b101;

  // Status byte layout
  localparam int unsigned STAT_FULL_BIT = 7;
  localparam int unsigned STAT_INIT_BIT = 1;
  localparam int unsigned STAT_ERR_BIT  = 0;

  // Synchronizer lanes
  localparam int unsigned SY_SHIFT = 0;
  localparam int unsigned SY_OUT   = 1;
  localparam int unsigned SY_DO    = 2;
  localparam int unsigned SY_RUN   = 3;
  localparam int unsigned SY_SET   = 4;
  localparam int unsigned SY_W     = 5;

  function automatic logic [WORD_W-1:0] status_byte(input logic full,
                                                    input logic init_done,
                                                    input logic err_last);
    logic [WORD_W-1:0] b;
    b = '0;
    b[STAT_FULL_BIT] = full;
    b[STAT_INIT_BIT] = init_done;
    b[STAT_ERR_BIT]  = err_last;
    return b;
  endfunction

endpackage

// File: rtl/fdc_buf.sv
// Sector buffer: DEPTH x 8 single-port synchronous RAM, read-first,
// one cycle read latency. No reset, contents survive device init.
// Ports: i_clk clock, i_we write enable, i_addr address,
//        i_wdata write byte, o_rdata registered read byte.
module fdc_buf
  import fdc_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fdc_sif.sv
// Floppy controller serial host interface.
// Receives 8-bit LSB-first commands and data over a strobed serial link,
// fills/empties a sector buffer, reports status and errors.
// Ports: PIN_CLK clock, PIN_RST sync active-high reset,
//        PIN_nSHIFT bit strobe, PIN_nOUT direction, PIN_nDO host data,
//        PIN_nRUN command start, PIN_nSET device init (all active low in),
//        PIN_nDI data to host, PIN_nTR transfer request,
//        PIN_nDONE idle, PIN_nERR error (all active low, registered).
module fdc_sif
  import fdc_pkg::*;
#(
  parameter int unsigned BUF_DEPTH   = 128,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic PIN_CLK,
  input  logic PIN_RST,
  input  logic PIN_nSHIFT,
  input  logic PIN_nOUT,
  input  logic PIN_nDO,
  input  logic PIN_nRUN,
  input  logic PIN_nSET,
  output logic PIN_nDI,
  output logic PIN_nTR,
  output logic PIN_nDONE,
  output logic PIN_nERR
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  // Input synchronizers, reset to the inactive level
  logic [SY_W-1:0] w_pins;
  logic [SY_W-1:0] r_sync [SYNC_STAGES];
  logic [SY_W-1:0] w_sync;

  assign w_pins = {PIN_nSET, PIN_nRUN, PIN_nDO, PIN_nOUT, PIN_nSHIFT};
  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge PIN_CLK) begin
    if (PIN_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '1;
      end
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // State and datapath registers
  fdc_state_e        r_state;
  tx_phase_e         r_tx_ph;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [PTR_W-1:0]  r_ptr;
  logic [WORD_W-1:0] r_shreg;
  logic              r_rx_gap;
  logic              r_full;
  logic              r_init_done;
  logic              r_err_last;
  logic              r_shift_d;
  logic              r_run_d;
  logic              r_set_d;
  logic              r_ndi;
  logic              r_ntr;
  logic              r_ndone;
  logic              r_nerr;

  fdc_state_e        w_state_nxt;
  tx_phase_e         w_tx_ph_nxt;
  logic [BIT_W-1:0]  w_bit_cnt_nxt;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [WORD_W-1:0] w_shreg_nxt;
  logic              w_rx_gap_nxt;
  logic              w_full_nxt;
  logic              w_init_nxt;
  logic              w_err_last_nxt;
  logic              w_ndi_nxt;
  logic              w_ntr_nxt;
  logic              w_ndone_nxt;
  logic              w_nerr_nxt;
  logic              w_we;
  logic [WORD_W-1:0] w_rdata;

  // Edge detection on synchronized copies
  logic              w_set_fall;
  logic              w_run_fall;
  logic              w_strobe;
  logic              w_out_n;
  logic [WORD_W-1:0] w_shin;

  assign w_set_fall = ~w_sync[SY_SET] & r_set_d;
  assign w_run_fall = ~w_sync[SY_RUN] & r_run_d;
  // Strobes only count while a word is requested; init takes priority
  assign w_strobe   = w_sync[SY_SHIFT] & ~r_shift_d & ~r_ntr & ~w_set_fall;
  assign w_out_n    = w_sync[SY_OUT];
  assign w_shin     = {~w_sync[SY_DO], r_shreg[WORD_W-1:1]};

  fdc_buf #(
    .DEPTH (BUF_DEPTH),
    .AW    (PTR_W)
  ) u_buf (
    .i_clk   (PIN_CLK),
    .i_we    (w_we),
    .i_addr  (r_ptr),
    .i_wdata (w_shin),
    .o_rdata (w_rdata)
  );

  // State register and datapath
  always_ff @(posedge PIN_CLK) begin
    if (PIN_RST) begin
      r_state     <= ST_IDLE;
      r_tx_ph     <= TX_FETCH;
      r_bit_cnt   <= '0;
      r_ptr       <= '0;
      r_shreg     <= '0;
      r_rx_gap    <= 1'b0;
      r_full      <= 1'b0;
      r_init_done <= 1'b0;
      r_err_last  <= 1'b0;
      r_shift_d   <= 1'b1;
      r_run_d     <= 1'b1;
      r_set_d     <= 1'b1;
      r_ndi       <= 1'b1;
      r_ntr       <= 1'b1;
      r_ndone     <= 1'b0;
      r_nerr      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_ph     <= w_tx_ph_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
      r_shreg     <= w_shreg_nxt;
      r_rx_gap    <= w_rx_gap_nxt;
      r_full      <= w_full_nxt;
      r_init_done <= w_init_nxt;
      r_err_last  <= w_err_last_nxt;
      r_shift_d   <= w_sync[SY_SHIFT];
      r_run_d     <= w_sync[SY_RUN];
      r_set_d     <= w_sync[SY_SET];
      r_ndi       <= w_ndi_nxt;
      r_ntr       <= w_ntr_nxt;
      r_ndone     <= w_ndone_nxt;
      r_nerr      <= w_nerr_nxt;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_ph_nxt    = r_tx_ph;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_ptr_nxt      = r_ptr;
    w_shreg_nxt    = r_shreg;
    w_rx_gap_nxt   = r_rx_gap;
    w_full_nxt     = r_full;
    w_init_nxt     = r_init_done;
    w_err_last_nxt = r_err_last;
    w_nerr_nxt     = r_nerr;
    w_we           = 1'b0;
    w_ntr_nxt      = 1'b1;
    w_ndi_nxt      = 1'b1;

    if (w_set_fall) begin
      w_state_nxt    = ST_IDLE;
      w_tx_ph_nxt    = TX_FETCH;
      w_bit_cnt_nxt  = '0;
      w_ptr_nxt      = '0;
      w_rx_gap_nxt   = 1'b0;
      w_full_nxt     = 1'b0;
      w_init_nxt     = 1'b1;
      w_err_last_nxt = 1'b0;
      w_nerr_nxt     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_run_fall) begin
            w_state_nxt   = ST_CMD;
            w_bit_cnt_nxt = '0;
            w_nerr_nxt    = 1'b1;
          end
        end
        ST_CMD: begin
          if (w_strobe) begin
            if (w_out_n) begin
              w_state_nxt = ST_ABORT;
            end else begin
              w_shreg_nxt   = w_shin;
              w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
              if (r_bit_cnt == BIT_W'(WORD_W - 1)) begin
                w_state_nxt = ST_DECODE;
              end
            end
          end
        end
        ST_DECODE: begin
          w_ptr_nxt     = '0;
          w_bit_cnt_nxt = '0;
          w_rx_gap_nxt  = 1'b0;
          w_tx_ph_nxt   = TX_FETCH;
          case (r_shreg[3:1])
            FN_FILL:   w_state_nxt = ST_RXDATA;
            FN_EMPTY:  w_state_nxt = ST_TXDATA;
            FN_STATUS: begin
              w_state_nxt = ST_STAT;
              w_shreg_nxt = status_byte(r_full, r_init_done, r_err_last);
            end
            default:   w_state_nxt = ST_ABORT;
          endcase
        end
        ST_RXDATA: begin
          // One idle cycle with nTR high after every stored byte
          if (r_rx_gap) begin
            w_rx_gap_nxt = 1'b0;
          end else if (w_strobe) begin
            if (w_out_n) begin
              w_state_nxt = ST_ABORT;
            end else begin
              w_shreg_nxt   = w_shin;
              w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
              if (r_bit_cnt == BIT_W'(WORD_W - 1)) begin
                w_we         = 1'b1;
                w_ptr_nxt    = r_ptr + PTR_W'(1);
                w_rx_gap_nxt = 1'b1;
                if (r_ptr == LAST_PTR) begin
                  w_full_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
                end
              end
            end
          end
        end
        ST_TXDATA: begin
          case (r_tx_ph)
            TX_FETCH: w_tx_ph_nxt = TX_LOAD;
            TX_LOAD: begin
              w_shreg_nxt = w_rdata;
              w_tx_ph_nxt = TX_SHIFT;
            end
            TX_SHIFT: begin
              if (w_strobe) begin
                if (!w_out_n) begin
                  w_state_nxt = ST_ABORT;
                end else begin
                  w_shreg_nxt   = {1'b0, r_shreg[WORD_W-1:1]};
                  w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                  if (r_bit_cnt == BIT_W'(WORD_W - 1)) begin
                    w_ptr_nxt   = r_ptr + PTR_W'(1);
                    w_tx_ph_nxt = TX_FETCH;
                    if (r_ptr == LAST_PTR) begin
                      w_state_nxt = ST_IDLE;
                    end
                  end
                end
              end
            end
            default: w_tx_ph_nxt = TX_FETCH;
          endcase
        end
        ST_STAT: begin
          if (w_strobe) begin
            if (!w_out_n) begin
              w_state_nxt = ST_ABORT;
            end else begin
              w_shreg_nxt   = {1'b0, r_shreg[WORD_W-1:1]};
              w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
              if (r_bit_cnt == BIT_W'(WORD_W - 1)) begin
                w_state_nxt = ST_IDLE;
              end
            end
          end
        end
        ST_ABORT: begin
          w_nerr_nxt     = 1'b0;
          w_err_last_nxt = 1'b1;
          w_bit_cnt_nxt  = '0;
          w_state_nxt    = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // Outputs follow the state being entered so they register in step
    case (w_state_nxt)
      ST_CMD:    w_ntr_nxt = 1'b0;
      ST_RXDATA: w_ntr_nxt = w_rx_gap_nxt;
      ST_TXDATA: begin
        if (w_tx_ph_nxt == TX_SHIFT) begin
          w_ntr_nxt = 1'b0;
          w_ndi_nxt = ~w_shreg_nxt[0];
        end
      end
      ST_STAT: begin
        w_ntr_nxt = 1'b0;
        w_ndi_nxt = ~w_shreg_nxt[0];
      end
      default: w_ntr_nxt = 1'b1;
    endcase
    w_ndone_nxt = (w_state_nxt != ST_IDLE);
  end

  assign PIN_nDI   = r_ndi;
  assign PIN_nTR   = r_ntr;
  assign PIN_nDONE = r_ndone;
  assign PIN_nERR  = r_nerr;

endmodule

// File: tb/tb_fdc_sif.sv
// Directed bench for fdc_sif: emulates the host side of the serial link.
module tb_fdc_sif;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned SYNC  = 2;

  logic clk;
  logic rst;
  logic nshift;
  logic nout;
  logic ndo;
  logic nrun;
  logic nset;
  wire  ndi;
  wire  ntr;
  wire  ndone;
  wire  nerr;

  int tests_run    = 0;
  int tests_failed = 0;
  int ntr_falls    = 0;
  logic ntr_q      = 1'b1;

  fdc_sif #(
    .BUF_DEPTH   (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .PIN_CLK    (clk),
    .PIN_RST    (rst),
    .PIN_nSHIFT (nshift),
    .PIN_nOUT   (nout),
    .PIN_nDO    (ndo),
    .PIN_nRUN   (nrun),
    .PIN_nSET   (nset),
    .PIN_nDI    (ndi),
    .PIN_nTR    (ntr),
    .PIN_nDONE  (ndone),
    .PIN_nERR   (nerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count transfer requests (nTR falling)
  always @(negedge clk) begin
    if (ntr_q === 1'b1 && ntr === 1'b0) ntr_falls++;
    ntr_q = ntr;
  end

  task automatic wait_ntr_low(input string what);
    int n;
    n = 0;
    while (ntr !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (ntr !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: nTR=%b after %0d cycles, want 0", what, ntr, n);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ntr_low("send_wait");
    for (int i = 0; i < 8; i++) begin
      ndo    = ~b[i];
      nshift = 1'b0;
      repeat (3) @(negedge clk);
      nshift = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic recv_byte(output logic [7:0] b);
    b = '0;
    wait_ntr_low("recv_wait");
    for (int i = 0; i < 8; i++) begin
      b[i]   = ~ndi;
      nshift = 1'b0;
      repeat (3) @(negedge clk);
      nshift = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic pulse_run();
    nrun = 1'b0;
    repeat (4) @(negedge clk);
    nrun = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_set();
    nset = 1'b0;
    repeat (4) @(negedge clk);
    nset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (ndone !== 1'b0) begin tests_failed++; $display("FAIL reset_ndone: got %b want 0", ndone); end
    tests_run++;
    if (ntr !== 1'b1) begin tests_failed++; $display("FAIL reset_ntr: got %b want 1", ntr); end
    tests_run++;
    if (nerr !== 1'b1) begin tests_failed++; $display("FAIL reset_nerr: got %b want 1", nerr); end
    tests_run++;
    if (ndi !== 1'b1) begin tests_failed++; $display("FAIL reset_ndi: got %b want 1", ndi); end
  endtask

  task automatic test_idle_strobe();
    int f0;
    f0 = ntr_falls;
    for (int i = 0; i < 4; i++) begin
      nshift = 1'b0;
      repeat (3) @(negedge clk);
      nshift = 1'b1;
      repeat (3) @(negedge clk);
    end
    tests_run++;
    if (ndone !== 1'b0) begin tests_failed++; $display("FAIL idle_strobe_ndone: got %b want 0", ndone); end
    tests_run++;
    if (ntr_falls - f0 !== 0) begin tests_failed++; $display("FAIL idle_strobe_ntr: got %0d requests want 0", ntr_falls - f0); end
  endtask

  task automatic test_init();
    logic [7:0] b;
    pulse_set();
    tests_run++;
    if (ndone !== 1'b0 || nerr !== 1'b1) begin
      tests_failed++; $display("FAIL init_outputs: nDONE=%b nERR=%b want 0 1", ndone, nerr);
    end
    nout = 1'b0;
    pulse_run();
    send_byte(8'o013);
    nout = 1'b1;
    recv_byte(b);
    nout = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (b !== 8'h02) begin tests_failed++; $display("FAIL init_status: got %h want 02", b); end
  endtask

  task automatic test_fill();
    int f0;
    f0 = ntr_falls;
    nout = 1'b0;
    pulse_run();
    send_byte(8'o001);
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
    repeat (4) @(negedge clk);
    tests_run++;
    if (ntr_falls - f0 !== 129) begin tests_failed++; $display("FAIL fill_ntr_count: got %0d want 129", ntr_falls - f0); end
    tests_run++;
    if (ndone !== 1'b0) begin tests_failed++; $display("FAIL fill_ndone: got %b want 0", ndone); end
    tests_run++;
    if (nerr !== 1'b1) begin tests_failed++; $display("FAIL fill_nerr: got %b want 1", nerr); end
  endtask

  task automatic test_empty();
    logic [7:0] b;
    nout = 1'b0;
    pulse_run();
    send_byte(8'o003);
    nout = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      recv_byte(b);
      tests_run++;
      if (b !== 8'(i)) begin tests_failed++; $display("FAIL empty_byte[%0d]: got %h want %h", i, b, 8'(i)); end
    end
    nout = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (ndone !== 1'b0 || ntr !== 1'b1) begin
      tests_failed++; $display("FAIL empty_end: nDONE=%b nTR=%b want 0 1", ndone, ntr);
    end
  endtask

  task automatic test_status();
    logic [7:0] b;
    nout = 1'b0;
    pulse_run();
    send_byte(8'o013);
    nout = 1'b1;
    recv_byte(b);
    nout = 1'b0;
    tests_run++;
    if (b !== 8'h82) begin tests_failed++; $display("FAIL status_full: got %h want 82", b); end
    repeat (4) @(negedge clk);
    pulse_run();
    send_byte(8'o007);
    repeat (6) @(negedge clk);
    tests_run++;
    if (nerr !== 1'b0 || ndone !== 1'b0) begin
      tests_failed++; $display("FAIL illegal_cmd: nERR=%b nDONE=%b want 0 0", nerr, ndone);
    end
    pulse_run();
    tests_run++;
    if (nerr !== 1'b1) begin tests_failed++; $display("FAIL run_clears_nerr: got %b want 1", nerr); end
    send_byte(8'o013);
    nout = 1'b1;
    recv_byte(b);
    nout = 1'b0;
    tests_run++;
    if (b !== 8'h83) begin tests_failed++; $display("FAIL status_err: got %h want 83", b); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_set_abort();
    logic [7:0] b;
    logic [7:0] exp;
    nout = 1'b0;
    pulse_run();
    send_byte(8'o001);
    for (int i = 0; i < 40; i++) send_byte(8'hA0 + 8'(i));
    nset = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    tests_run++;
    if (ndone !== 1'b0) begin tests_failed++; $display("FAIL set_ndone: got %b want 0", ndone); end
    tests_run++;
    if (nerr !== 1'b1) begin tests_failed++; $display("FAIL set_nerr: got %b want 1", nerr); end
    @(negedge clk);
    nset = 1'b1;
    repeat (4) @(negedge clk);
    pulse_run();
    send_byte(8'o013);
    nout = 1'b1;
    recv_byte(b);
    nout = 1'b0;
    tests_run++;
    if (b !== 8'h02) begin tests_failed++; $display("FAIL set_status: got %h want 02", b); end
    repeat (4) @(negedge clk);
    // Buffer contents survive init: 40 new bytes then the old pattern
    pulse_run();
    send_byte(8'o003);
    nout = 1'b1;
    for (int i = 0; i < 42; i++) begin
      recv_byte(b);
      exp = (i < 40) ? 8'hA0 + 8'(i) : 8'(i);
      tests_run++;
      if (b !== exp) begin tests_failed++; $display("FAIL kept_byte[%0d]: got %h want %h", i, b, exp); end
    end
    pulse_set();
    nout = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (ndone !== 1'b0 || ndi !== 1'b1) begin
      tests_failed++; $display("FAIL set_during_tx: nDONE=%b nDI=%b want 0 1", ndone, ndi);
    end
  endtask

  task automatic test_dir_abort();
    logic [7:0] b;
    nout = 1'b0;
    pulse_run();
    send_byte(8'o001);
    wait_ntr_low("dir_wait");
    nout = 1'b1;
    repeat (4) @(negedge clk);
    nshift = 1'b0;
    repeat (3) @(negedge clk);
    nshift = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++;
    if (nerr !== 1'b0 || ndone !== 1'b0 || ntr !== 1'b1) begin
      tests_failed++; $display("FAIL dir_abort: nERR=%b nDONE=%b nTR=%b want 0 0 1", nerr, ndone, ntr);
    end
    nout = 1'b0;
    repeat (3) @(negedge clk);
    pulse_run();
    tests_run++;
    if (nerr !== 1'b1 || ndone !== 1'b1) begin
      tests_failed++; $display("FAIL dir_run_clear: nERR=%b nDONE=%b want 1 1", nerr, ndone);
    end
    // A second nRUN while busy must not disturb the command in progress
    pulse_run();
    send_byte(8'o013);
    nout = 1'b1;
    recv_byte(b);
    nout = 1'b0;
    tests_run++;
    if (b !== 8'h03) begin tests_failed++; $display("FAIL dir_status: got %h want 03", b); end
    repeat (4) @(negedge clk);
    tests_run++;
    if (ndone !== 1'b0) begin tests_failed++; $display("FAIL final_ndone: got %b want 0", ndone); end
  endtask

  initial begin
    rst    = 1'b1;
    nshift = 1'b1;
    nout   = 1'b0;
    ndo    = 1'b1;
    nrun   = 1'b1;
    nset   = 1'b1;
    @(negedge clk);
    test_reset();
    test_idle_strobe();
    test_init();
    test_fill();
    test_empty();
    test_status();
    test_set_abort();
    test_dir_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
